// File: rtl/ghost_dir_ai.sv
// Ghost direction chooser: scatter/chase/frightened mode timer plus a once-per-frame
// pick of the next W/A/S/D keycode from position, target and wall flags.

module ghost_dir_lane #(
  parameter int LANE = 0,
  parameter int STEP = 1
) (
  input  logic [9:0]  gx,
  input  logic [9:0]  gy,
  input  logic [9:0]  tx,
  input  logic [9:0]  ty,
  output logic [10:0] metric
);
  localparam logic [10:0] S = 11'(STEP);
  logic [10:0] cx, cy, dx, dy, gx1, gy1, tx1, ty1;

  always_comb begin
    gx1 = {1'b0, gx};
    gy1 = {1'b0, gy};
    tx1 = {1'b0, tx};
    ty1 = {1'b0, ty};
    cx  = gx1;
    cy  = gy1;
    // lane order is up, left, down, right; screen Y grows downward
    if (LANE == 0)      cy = (gy1 < S) ? 11'd0 : gy1 - S;
    else if (LANE == 1) cx = (gx1 < S) ? 11'd0 : gx1 - S;
    else if (LANE == 2) cy = gy1 + S;
    else                cx = gx1 + S;
    dx = (cx >= tx1) ? cx - tx1 : tx1 - cx;
    dy = (cy >= ty1) ? cy - ty1 : ty1 - cy;
    metric = dx + dy;
  end
endmodule

module ghost_dir_ai #(
  parameter int          SCATTER_SEC = 7,
  parameter int          CHASE_SEC   = 20,
  parameter int          FRIGHT_SEC  = 6,
  parameter int          STEP        = 1,
  parameter logic [9:0]  CORNER_X    = 10'd432,
  parameter logic [9:0]  CORNER_Y    = 10'd0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       sec,
  input  logic [9:0] ghostX,
  input  logic [9:0] ghostY,
  input  logic [9:0] pacX,
  input  logic [9:0] pacY,
  input  logic [3:0] blocked,
  input  logic       power_eaten,
  input  logic       lifeDown,
  input  logic       restart,
  output logic [7:0] dir_keycode,
  output logic [1:0] mode,
  output logic       frightened
);
  localparam int          NUM_LANES = 4;
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [1:0] {SCATTER = 2'd0, CHASE = 2'd1, FRIGHT = 2'd2} mode_e;

  mode_e       mode_q, mode_d, smode_q, smode_d;
  logic [7:0]  cnt_q, cnt_d, scnt_q, scnt_d, cnt_inc;
  logic [15:0] lfsr_q;
  logic [1:0]  dir_q, dir_d, rev, pick, idx;
  logic        frame_q, pend_q, pend_d, fright_q, trans, tick, rev_ok, found;
  logic [NUM_LANES-1:0]       blk, cand;
  logic [NUM_LANES-1:0][10:0] metric;
  logic [10:0] best;
  logic [9:0]  tx, ty;

  assign tick = frame_clk & ~frame_q;
  assign blk  = {blocked[0], blocked[1], blocked[2], blocked[3]};
  assign rev  = dir_q ^ 2'd2;
  assign tx   = (mode_q == CHASE) ? pacX : CORNER_X;
  assign ty   = (mode_q == CHASE) ? pacY : CORNER_Y;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    ghost_dir_lane #(.LANE(i), .STEP(STEP)) u_lane (
      .gx(ghostX), .gy(ghostY), .tx(tx), .ty(ty), .metric(metric[i])
    );
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode_q   <= SCATTER;
      smode_q  <= SCATTER;
      cnt_q    <= '0;
      scnt_q   <= '0;
      lfsr_q   <= SEED;
      frame_q  <= 1'b0;
      pend_q   <= 1'b0;
      dir_q    <= 2'd1;
      fright_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      smode_q  <= smode_d;
      cnt_q    <= cnt_d;
      scnt_q   <= scnt_d;
      lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      frame_q  <= frame_clk;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      fright_q <= (mode_d == FRIGHT);
    end
  end

  // mode timer; FRIGHT expiry resumes the interrupted phase where it left off
  always_comb begin
    mode_d  = mode_q;
    smode_d = smode_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    trans   = 1'b0;
    cnt_inc = cnt_q + 8'd1;
    if (lifeDown || restart) begin
      mode_d = SCATTER;
      cnt_d  = '0;
    end else if (power_eaten) begin
      cnt_d = '0;
      if (mode_q != FRIGHT) begin
        smode_d = mode_q;
        scnt_d  = cnt_q;
        mode_d  = FRIGHT;
        trans   = 1'b1;
      end
    end else if (sec) begin
      cnt_d = cnt_inc;
      case (mode_q)
        SCATTER: if (cnt_inc == 8'(SCATTER_SEC)) begin mode_d = CHASE;   cnt_d = '0; trans = 1'b1; end
        CHASE:   if (cnt_inc == 8'(CHASE_SEC))   begin mode_d = SCATTER; cnt_d = '0; trans = 1'b1; end
        FRIGHT:  if (cnt_inc == 8'(FRIGHT_SEC))  begin mode_d = smode_q; cnt_d = scnt_q; trans = 1'b1; end
        default: begin mode_d = SCATTER; cnt_d = '0; end
      endcase
    end
  end

  // direction pick; strict '<' keeps the earliest lane on metric ties
  always_comb begin
    rev_ok = ~blk[rev];
    found  = 1'b0;
    pick   = dir_q;
    best   = '0;
    idx    = '0;
    for (int i = 0; i < NUM_LANES; i++)
      cand[i] = ~blk[i] && (2'(i) != rev);
    if (mode_q == FRIGHT) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        idx = lfsr_q[1:0] + 2'(k);
        if (!found && cand[idx]) begin
          found = 1'b1;
          pick  = idx;
        end
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++)
        if (cand[i] && (!found || metric[i] < best)) begin
          found = 1'b1;
          pick  = 2'(i);
          best  = metric[i];
        end
    end
    dir_d  = dir_q;
    pend_d = pend_q;
    if (tick) begin
      if (pend_q && rev_ok) begin
        dir_d  = rev;
        pend_d = 1'b0;
      end else if (found) dir_d = pick;
      else if (rev_ok)    dir_d = rev;
    end
    if (trans) pend_d = 1'b1;
    if (lifeDown || restart) pend_d = 1'b0;
  end

  always_comb begin
    case (dir_q)
      2'd0:    dir_keycode = 8'h1A;
      2'd1:    dir_keycode = 8'h04;
      2'd2:    dir_keycode = 8'h16;
      default: dir_keycode = 8'h07;
    endcase
  end

  assign mode       = mode_q;
  assign frightened = fright_q;
endmodule

// File: tb/tb_ghost_dir_ai.sv
// Directed bench for ghost_dir_ai: mode timing, targeting, dead ends, frightened
// random walk and its reproducibility after reset, and input priority.

module tb_ghost_dir_ai;
  logic       Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, sec = 1'b0;
  logic [9:0] ghostX = 10'd100, ghostY = 10'd100, pacX = 10'd100, pacY = 10'd40;
  logic [3:0] blocked = 4'b0000;
  logic       power_eaten = 1'b0, lifeDown = 1'b0, restart = 1'b0;
  logic [7:0] dir_keycode;
  logic [1:0] mode;
  logic       frightened;

  int n_chk = 0, n_pass = 0;
  logic [7:0] seq_a [40];
  logic [7:0] seq_b [40];

  ghost_dir_ai dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .sec(sec),
    .ghostX(ghostX), .ghostY(ghostY), .pacX(pacX), .pacY(pacY),
    .blocked(blocked), .power_eaten(power_eaten), .lifeDown(lifeDown),
    .restart(restart), .dir_keycode(dir_keycode), .mode(mode),
    .frightened(frightened)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // returns one Clk after the tick cycle, so the new decision is visible
  task automatic tick();
    step();
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
  endtask

  task automatic pulse_sec(input int n);
    repeat (n) begin
      sec = 1'b1;
      step();
      sec = 1'b0;
      step();
    end
  endtask

  task automatic pulse_pe();
    power_eaten = 1'b1;
    step();
    power_eaten = 1'b0;
  endtask

  function automatic logic [7:0] rev_kc(input logic [7:0] kc);
    case (kc)
      8'h1A:   return 8'h16;
      8'h16:   return 8'h1A;
      8'h04:   return 8'h07;
      default: return 8'h04;
    endcase
  endfunction

  task automatic run_fright(input bit second);
    logic [7:0] prev;
    bit seen_l, seen_r;
    seen_l  = 1'b0;
    seen_r  = 1'b0;
    Reset   = 1'b1;
    blocked = 4'b0000;
    step();
    chk("rst_dir", dir_keycode, 8'h04);
    chk("rst_mode", mode, 2'd0);
    chk("rst_fright", frightened, 1'b0);
    Reset = 1'b0;
    pulse_pe();
    chk("pe_mode", mode, 2'd2);
    chk("pe_fright", frightened, 1'b1);
    tick();
    chk("pe_reverse", dir_keycode, 8'h07);
    blocked = 4'b0111;
    tick();
    chk("force_up", dir_keycode, 8'h1A);
    blocked = 4'b0000;
    for (int n = 0; n < 40; n++) begin
      prev = dir_keycode;
      tick();
      if (second) seq_b[n] = dir_keycode;
      else        seq_a[n] = dir_keycode;
      chk("frt_norev", 32'(dir_keycode == rev_kc(prev)), 32'd0);
      if (dir_keycode == 8'h04) seen_l = 1'b1;
      if (dir_keycode == 8'h07) seen_r = 1'b1;
    end
    chk("frt_seen_left", 32'(seen_l), 32'd1);
    chk("frt_seen_right", 32'(seen_r), 32'd1);
    chk("frt_mode_hold", mode, 2'd2);
  endtask

  initial begin
    int diffs;
    step();
    step();
    Reset = 1'b0;
    chk("reset_dir", dir_keycode, 8'h04);
    chk("reset_mode", mode, 2'd0);
    chk("reset_fright", frightened, 1'b0);

    pulse_sec(6);
    chk("scatter_6s", mode, 2'd0);
    pulse_sec(1);
    chk("scatter_to_chase", mode, 2'd1);

    tick();
    chk("chase_pending_rev", dir_keycode, 8'h07);
    blocked = 4'b1011;
    tick();
    chk("dead_end_rev", dir_keycode, 8'h04);
    blocked = 4'b0000;
    tick();
    chk("chase_up", dir_keycode, 8'h1A);
    blocked = 4'b1000;
    tick();
    chk("chase_tie_left", dir_keycode, 8'h04);
    blocked = 4'b1111;
    tick();
    chk("all_blocked_hold", dir_keycode, 8'h04);
    blocked = 4'b0000;

    pulse_sec(5);
    chk("chase_5s", mode, 2'd1);
    pulse_pe();
    chk("fright_mode", mode, 2'd2);
    chk("fright_flag", frightened, 1'b1);
    tick();
    chk("fright_rev", dir_keycode, 8'h07);
    pulse_sec(5);
    chk("fright_5s", mode, 2'd2);
    pulse_sec(1);
    chk("fright_expire", mode, 2'd1);
    chk("fright_flag_clr", frightened, 1'b0);
    pulse_sec(14);
    chk("restored_cnt_19", mode, 2'd1);
    pulse_sec(1);
    chk("chase_to_scatter", mode, 2'd0);

    pulse_pe();
    pulse_sec(3);
    power_eaten = 1'b1;
    sec         = 1'b1;
    lifeDown    = 1'b1;
    step();
    power_eaten = 1'b0;
    sec         = 1'b0;
    lifeDown    = 1'b0;
    chk("prio_mode", mode, 2'd0);
    chk("prio_fright", frightened, 1'b0);
    chk("life_dir_kept", dir_keycode, 8'h07);
    pulse_sec(6);
    chk("prio_cnt_cleared", mode, 2'd0);
    pulse_sec(1);
    chk("prio_to_chase", mode, 2'd1);
    pulse_sec(19);
    chk("chase_19s", mode, 2'd1);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("restart_mode", mode, 2'd0);

    run_fright(1'b0);
    run_fright(1'b1);
    diffs = 0;
    for (int n = 0; n < 40; n++)
      if (seq_a[n] !== seq_b[n]) diffs++;
    chk("lfsr_repeat", diffs, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
